// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared LPC cycle-type, SYNC and target state definitions
package lpc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CTDIR,
        ST_ADDR,
        ST_WDATA,
        ST_HTAR0,
        ST_HTAR1,
        ST_SYNC,
        ST_RDATA,
        ST_TTAR0,
        ST_TTAR1,
        ST_IGNORE
    } lpc_state_t;

    localparam logic [3:0] CT_IORD    = 4'b0000;
    localparam logic [3:0] CT_IOWR    = 4'b0010;
    localparam logic [3:0] START_ISA  = 4'b0000;
    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] TAR_DRIVE  = 4'hF;

endpackage

// File: rtl/lpc_io_target.sv
// rtl/lpc_io_target.sv - LPC I/O-cycle target turning window hits into register strobes
module lpc_io_target
    import lpc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h03F8,
    parameter int          ADDR_W     = 3,
    parameter int          SYNC_WAITS = 0
) (
    input  logic              lpc_clk,
    input  logic              lpc_rst,
    input  logic              lpc_frame,
    input  logic [3:0]        lpc_ad_in,
    output logic [3:0]        lpc_ad_out,
    output logic              lpc_ad_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr,
    output logic [7:0]        reg_wdata,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata
);

    localparam logic [7:0] WAITS = 8'(SYNC_WAITS);

    lpc_state_t        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [11:0]       addr_q, addr_d;
    logic [15:0]       addr_full;
    logic              is_wr_q, is_wr_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [ADDR_W-1:0] reg_addr_d;
    logic [7:0]        reg_wdata_d;
    logic              reg_wr_d, reg_rd_d, oe_d;
    logic [3:0]        ad_out_d;

    // Three address nibbles already shifted in plus the one on the bus now.
    assign addr_full = {addr_q, lpc_ad_in};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        is_wr_d     = is_wr_q;
        rdata_d     = rdata_q;
        reg_addr_d  = reg_addr;
        reg_wdata_d = reg_wdata;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        oe_d        = 1'b0;
        ad_out_d    = TAR_DRIVE;

        if (!lpc_frame) begin
            // LFRAME# low anywhere restarts START detection; pending strobes are dropped.
            state_d = (lpc_ad_in == START_ISA) ? ST_CTDIR : ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_CTDIR: begin
                    cnt_d = '0;
                    if (lpc_ad_in[3:1] == CT_IORD[3:1]) begin
                        is_wr_d = 1'b0;
                        state_d = ST_ADDR;
                    end else if (lpc_ad_in[3:1] == CT_IOWR[3:1]) begin
                        is_wr_d = 1'b1;
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    addr_d = addr_full[11:0];
                    if (cnt_q == 8'd3) begin
                        cnt_d = '0;
                        if (addr_full[15:ADDR_W] == BASE_ADDR[15:ADDR_W]) begin
                            reg_addr_d = addr_full[ADDR_W-1:0];
                            if (is_wr_q) begin
                                state_d = ST_WDATA;
                            end else begin
                                state_d  = ST_HTAR0;
                                reg_rd_d = 1'b1;
                            end
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_WDATA: begin
                    if (cnt_q == 8'd0) begin
                        reg_wdata_d[3:0] = lpc_ad_in;
                        cnt_d            = 8'd1;
                    end else begin
                        reg_wdata_d[7:4] = lpc_ad_in;
                        reg_wr_d         = 1'b1;
                        state_d          = ST_HTAR0;
                    end
                end
                ST_HTAR0: begin
                    if (!is_wr_q) begin
                        rdata_d = reg_rdata;
                    end
                    state_d = ST_HTAR1;
                end
                ST_HTAR1: begin
                    cnt_d   = '0;
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (cnt_q == WAITS) begin
                        cnt_d   = '0;
                        state_d = is_wr_q ? ST_TTAR0 : ST_RDATA;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_RDATA: begin
                    if (cnt_q == 8'd0) begin
                        cnt_d = 8'd1;
                    end else begin
                        state_d = ST_TTAR0;
                    end
                end
                ST_TTAR0: state_d = ST_TTAR1;
                ST_TTAR1: state_d = ST_IDLE;
                default:  state_d = state_q;
            endcase
        end

        // Pad drive is registered, so it follows the state being entered.
        case (state_d)
            ST_SYNC: begin
                oe_d     = 1'b1;
                ad_out_d = (cnt_d < WAITS) ? SYNC_SHORT : SYNC_READY;
            end
            ST_RDATA: begin
                oe_d     = 1'b1;
                ad_out_d = (cnt_d == 8'd0) ? rdata_d[3:0] : rdata_d[7:4];
            end
            ST_TTAR0: begin
                oe_d     = 1'b1;
                ad_out_d = TAR_DRIVE;
            end
            default: begin
                oe_d     = 1'b0;
                ad_out_d = TAR_DRIVE;
            end
        endcase
    end

    always_ff @(posedge lpc_clk or negedge lpc_rst) begin
        if (!lpc_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            is_wr_q    <= 1'b0;
            rdata_q    <= '0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_wr     <= 1'b0;
            reg_rd     <= 1'b0;
            lpc_ad_oe  <= 1'b0;
            lpc_ad_out <= TAR_DRIVE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            is_wr_q    <= is_wr_d;
            rdata_q    <= rdata_d;
            reg_addr   <= reg_addr_d;
            reg_wdata  <= reg_wdata_d;
            reg_wr     <= reg_wr_d;
            reg_rd     <= reg_rd_d;
            lpc_ad_oe  <= oe_d;
            lpc_ad_out <= ad_out_d;
        end
    end

endmodule

// File: tb/tb_lpc_io_target.sv
// tb/tb_lpc_io_target.sv - self-checking bench for lpc_io_target
module tb_lpc_io_target;
    import lpc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame;
    logic [3:0] ad_in;
    logic [7:0] reg_rdata;
    logic [3:0] ad_out0, ad_out1;
    logic       oe0, oe1, wr0, wr1, rd0, rd1;
    logic [2:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       sel = 1'b0;
    logic [7:0] rd_base = 8'h00;
    logic [7:0] pops = 8'h00;
    int         checks = 0;
    int         errors = 0;
    logic [15:0] win_base = 16'h03F8;
    logic [3:0]  ct_tab [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h8, 4'hE};

    always #5 clk = ~clk;

    // Register-file stand-in: the value seen changes after every read pop.
    assign reg_rdata = rd_base ^ pops;
    always @(posedge clk) if (sel ? rd1 : rd0) pops <= pops + 8'd1;

    lpc_io_target #(.BASE_ADDR(16'h03F8), .ADDR_W(3), .SYNC_WAITS(0)) u_dut0 (
        .lpc_clk(clk), .lpc_rst(rst_n), .lpc_frame(frame), .lpc_ad_in(ad_in),
        .lpc_ad_out(ad_out0), .lpc_ad_oe(oe0), .reg_addr(addr0), .reg_wr(wr0),
        .reg_wdata(wdata0), .reg_rd(rd0), .reg_rdata(reg_rdata)
    );

    lpc_io_target #(.BASE_ADDR(16'h03F8), .ADDR_W(3), .SYNC_WAITS(2)) u_dut1 (
        .lpc_clk(clk), .lpc_rst(rst_n), .lpc_frame(frame), .lpc_ad_in(ad_in),
        .lpc_ad_out(ad_out1), .lpc_ad_oe(oe1), .reg_addr(addr1), .reg_wr(wr1),
        .reg_wdata(wdata1), .reg_rd(rd1), .reg_rdata(reg_rdata)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One host cycle; kill_mode 1 aborts with LFRAME# at period kill_at, 2 resets there.
    task automatic run_cycle(input string tag, input logic [3:0] ct, input logic [15:0] addr,
                             input logic [7:0] data, input int startlen,
                             input int kill_mode, input int kill_at);
        bit         is_rd, is_wr, hit, live, xoe, xwr, xrd;
        int         nhost, total, strobe_p, waits;
        logic [3:0] host_nib[$];
        logic [3:0] resp[$];
        logic [3:0] o_ad;
        logic       o_oe, o_wr, o_rd;
        logic [2:0] o_addr;
        logic [7:0] o_wdata;

        is_rd = (ct[3:1] == 3'b000);
        is_wr = (ct[3:1] == 3'b001);
        hit   = (is_rd || is_wr) && (addr[15:3] == win_base[15:3]);
        waits = sel ? 2 : 0;
        rd_base = data ^ pops;

        host_nib.push_back(ct);
        for (int i = 3; i >= 0; i--) host_nib.push_back(addr[i*4 +: 4]);
        if (is_wr) begin
            host_nib.push_back(data[3:0]);
            host_nib.push_back(data[7:4]);
        end
        host_nib.push_back(4'hF);
        host_nib.push_back(4'hF);
        nhost = startlen + host_nib.size();

        if (hit) begin
            for (int i = 0; i < waits; i++) resp.push_back(SYNC_SHORT);
            resp.push_back(SYNC_READY);
            if (is_rd) begin
                resp.push_back(data[3:0]);
                resp.push_back(data[7:4]);
            end
            resp.push_back(TAR_DRIVE);
        end
        strobe_p = startlen + 1 + 4 + (is_wr ? 2 : 0) + 1;
        total = nhost + resp.size() + 3;
        if (kill_mode != 0 && total < kill_at + 5) total = kill_at + 5;

        for (int n = 1; n <= total; n++) begin
            @(negedge clk);
            o_oe    = sel ? oe1 : oe0;
            o_ad    = sel ? ad_out1 : ad_out0;
            o_wr    = sel ? wr1 : wr0;
            o_rd    = sel ? rd1 : rd0;
            o_addr  = sel ? addr1 : addr0;
            o_wdata = sel ? wdata1 : wdata0;
            live = (kill_mode == 0) || (n <= kill_at);
            xoe  = live && hit && (n > nhost) && (n <= nhost + resp.size());
            xwr  = live && hit && is_wr && (n == strobe_p);
            xrd  = live && hit && is_rd && (n == strobe_p);
            check($sformatf("%s oe p%0d", tag, n), 16'(o_oe), 16'(xoe));
            if (xoe) check($sformatf("%s lad p%0d", tag, n), 16'(o_ad), 16'(resp[n-nhost-1]));
            check($sformatf("%s wr p%0d", tag, n), 16'(o_wr), 16'(xwr));
            check($sformatf("%s rd p%0d", tag, n), 16'(o_rd), 16'(xrd));
            if (xwr) check({tag, " wdata"}, 16'(o_wdata), 16'(data));
            if (xwr || xrd) check({tag, " addr"}, 16'(o_addr), 16'(addr[2:0]));

            if (kill_mode == 2 && n == kill_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, " async oe"}, 16'(sel ? oe1 : oe0), 16'h0);
                check({tag, " async strobes"}, 16'({sel ? wr1 : wr0, sel ? rd1 : rd0}), 16'h0);
            end
            if (kill_mode == 2 && n == kill_at + 1) rst_n = 1'b1;

            if (n <= startlen) begin
                frame = 1'b0;
                ad_in = START_ISA;
            end else if (kill_mode == 1 && n >= kill_at && n < kill_at + 4) begin
                frame = 1'b0;
                ad_in = 4'hF;
            end else if (kill_mode != 0 && n >= kill_at) begin
                frame = 1'b1;
                ad_in = 4'hF;
            end else if (n <= nhost) begin
                frame = 1'b1;
                ad_in = host_nib[n-startlen-1];
            end else begin
                frame = 1'b1;
                ad_in = 4'hF;
            end
        end
    endtask

    initial begin
        logic [3:0]  ct;
        logic [15:0] addr;
        int          sl, km, ka;

        rst_n = 1'b0;
        frame = 1'b1;
        ad_in = 4'hF;
        repeat (10) @(negedge clk);
        check("rst oe", 16'({oe0, oe1}), 16'h0);
        check("rst lad", 16'({ad_out0, ad_out1}), 16'h00FF);
        check("rst strobes", 16'({wr0, rd0, wr1, rd1}), 16'h0);
        check("rst addr/wdata", 16'({addr0, wdata0}), 16'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        sel = 1'b0;
        run_cycle("wr3f8", CT_IOWR, 16'h03F8, 8'h5A, 1, 0, 0);
        run_cycle("rd3fd", CT_IORD, 16'h03FD, 8'h61, 1, 0, 0);
        run_cycle("rd2f8", CT_IORD, 16'h02F8, 8'h33, 1, 0, 0);
        run_cycle("wr080", CT_IOWR, 16'h0080, 8'h80, 1, 0, 0);
        run_cycle("rd3f8", CT_IORD, 16'h03F8, 8'hC4, 1, 0, 0);
        run_cycle("abort_addr2", CT_IOWR, 16'h03F8, 8'h77, 1, 1, 5);
        run_cycle("rd3fd_after", CT_IORD, 16'h03FD, 8'h9E, 1, 0, 0);
        run_cycle("abort_rdata0", CT_IORD, 16'h03FA, 8'hB2, 1, 1, 10);
        run_cycle("rst_rdata1", CT_IORD, 16'h03FB, 8'h5C, 1, 2, 11);
        run_cycle("long_start", CT_IOWR, 16'h03FF, 8'hE1, 3, 0, 0);
        sel = 1'b1;
        run_cycle("waits_rd3f8", CT_IORD, 16'h03F8, 8'h2D, 1, 0, 0);
        run_cycle("waits_wr3fc", CT_IOWR, 16'h03FC, 8'hA5, 1, 0, 0);

        for (int it = 0; it < 40; it++) begin
            sel = 1'($urandom_range(0, 1));
            ct  = ct_tab[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) != 0) addr = {win_base[15:3], 3'($urandom_range(0, 7))};
            else addr = 16'($urandom);
            sl = $urandom_range(1, 3);
            km = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 2)) : 0;
            ka = sl + int'($urandom_range(1, 14));
            run_cycle($sformatf("rnd%0d", it), ct, addr, 8'($urandom), sl, km, ka);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
